id_stage_pipe: RTL and testbench

//  Parametrised decode stage with its own ID/EX pipeline register. Decodes the IF/ID instruction

---
 rtl/id_stage_pipe.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
//   RV32I decode stage with its own ID/EX pipeline register.
//   - Combinational decode (controller + immediate generator) of in_instr.
//   - Internal register file (NREGS x XLEN, register 0 hard-wired to zero),
//     written from the write-back port.
//   - Load-use hazard detection: stalls IF/ID and lets a bubble drain into EX.
//   - Valid/ready handshake towards IF/ID (in_*) and towards EX (out_*).
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   flush                   kill the entering instruction and the ID/EX entry
//   in_valid/in_ready       IF/ID handshake; in_instr, in_pc payload
//   wb_we/wb_addr/wb_data   register-file write port
//   out_valid/out_ready     ID/EX handshake; out_pc, rs1_data, rs2_data,
//                           rd_addr, immediate, ex_ctrl, mem_ctrl, wb_ctrl
//   stall                   load-use stall (combinational)
//
// Configuration macro
//   ID_WB_BYPASS_EN  when defined, a register read that hits the address
//                    being written this cycle returns wb_data instead of
//                    the old register contents.
// ---------------------------------------------------------------------------
package id_stage_pkg;

    typedef struct packed {
        logic [3:0] alu_op;      // {funct7[5] or 0, funct3}; 4'b1000 = subtract
        logic       alu_src_imm; // operand B is the immediate
        logic [1:0] op_a_sel;    // 0: rs1, 1: pc, 2: zero
        logic       branch;
        logic [2:0] cmp_op;      // branch condition (funct3)
        logic       jump;
        logic       jalr;
    } ex_control_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;    // funct3 of the load/store
    } mem_control_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic link;              // write pc+4 (JAL/JALR)
    } wb_control_t;

endpackage

module id_stage_pipe
    import id_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [XLEN-1:0]    in_pc,
    input  logic               wb_we,
    input  logic [AW-1:0]      wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    rs1_data,
    output logic [XLEN-1:0]    rs2_data,
    output logic [AW-1:0]      rd_addr,
    output logic [XLEN-1:0]    immediate,
    output ex_control_t        ex_ctrl,
    output mem_control_t       mem_ctrl,
    output wb_control_t        wb_ctrl,
    output logic               stall
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ---------------- register file ----------------
    logic [XLEN-1:0] regs_q [NREGS];
    logic            rf_we_s;

    // Register read: register 0 and out-of-range addresses read as zero.
    function automatic logic [XLEN-1:0] rf_read(input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        if ((addr == {AW{1'b0}}) || (int'(addr) >= NREGS)) begin
            val = {XLEN{1'b0}};
        end
`ifdef ID_WB_BYPASS_EN
        else if (rf_we_s && (wb_addr == addr)) begin
            val = wb_data;
        end
`endif
        else begin
            val = regs_q[addr];
        end
        return val;
    endfunction

    // Write-back enable: register 0 is never written.
    always_comb begin
        rf_we_s = wb_we && (wb_addr != {AW{1'b0}}) && (int'(wb_addr) < NREGS);
    end

    // Register file storage, cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
        end else if (rf_we_s) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // ---------------- decode ----------------
    logic [6:0]        opcode_s;
    logic [2:0]        funct3_s;
    logic [AW-1:0]     rs1_addr_s;
    logic [AW-1:0]     rs2_addr_s;
    logic [AW-1:0]     rd_addr_s;
    logic              rs1_used_s;
    logic              rs2_used_s;
    logic signed [31:0] imm32_s;
    ex_control_t       ex_dec_s;
    mem_control_t      mem_dec_s;
    wb_control_t       wb_dec_s;

    // Controller and immediate generator.
    always_comb begin
        opcode_s   = in_instr[6:0];
        funct3_s   = in_instr[14:12];
        rs1_addr_s = AW'(in_instr[19:15]);
        rs2_addr_s = AW'(in_instr[24:20]);
        rd_addr_s  = AW'(in_instr[11:7]);
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b0;
        imm32_s    = 32'sd0;
        ex_dec_s   = '0;
        mem_dec_s  = '0;
        wb_dec_s   = '0;
        case (opcode_s)
            OPC_OP: begin
                rs2_used_s         = 1'b1;
                ex_dec_s.alu_op    = {in_instr[30], funct3_s};
                wb_dec_s.reg_write = 1'b1;
            end
            OPC_OPIMM: begin
                // Only the shift-right immediates carry funct7[5] (SRAI).
                ex_dec_s.alu_op      = {(funct3_s == 3'b101) ? in_instr[30] : 1'b0, funct3_s};
                ex_dec_s.alu_src_imm = 1'b1;
                wb_dec_s.reg_write   = 1'b1;
                imm32_s              = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_LOAD: begin
                ex_dec_s.alu_src_imm = 1'b1;
                mem_dec_s.mem_read   = 1'b1;
                mem_dec_s.mem_size   = funct3_s;
                wb_dec_s.reg_write   = 1'b1;
                wb_dec_s.mem_to_reg  = 1'b1;
                imm32_s              = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_STORE: begin
                rs2_used_s           = 1'b1;
                ex_dec_s.alu_src_imm = 1'b1;
                mem_dec_s.mem_write  = 1'b1;
                mem_dec_s.mem_size   = funct3_s;
                imm32_s              = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OPC_BRANCH: begin
                rs2_used_s       = 1'b1;
                ex_dec_s.alu_op  = 4'b1000;
                ex_dec_s.branch  = 1'b1;
                ex_dec_s.cmp_op  = funct3_s;
                imm32_s          = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                                    in_instr[11:8], 1'b0};
            end
            OPC_LUI: begin
                rs1_used_s           = 1'b0;
                ex_dec_s.alu_src_imm = 1'b1;
                ex_dec_s.op_a_sel    = 2'd2;
                wb_dec_s.reg_write   = 1'b1;
                imm32_s              = {in_instr[31:12], 12'h000};
            end
            OPC_AUIPC: begin
                rs1_used_s           = 1'b0;
                ex_dec_s.alu_src_imm = 1'b1;
                ex_dec_s.op_a_sel    = 2'd1;
                wb_dec_s.reg_write   = 1'b1;
                imm32_s              = {in_instr[31:12], 12'h000};
            end
            OPC_JAL: begin
                rs1_used_s           = 1'b0;
                ex_dec_s.alu_src_imm = 1'b1;
                ex_dec_s.op_a_sel    = 2'd1;
                ex_dec_s.jump        = 1'b1;
                wb_dec_s.reg_write   = 1'b1;
                wb_dec_s.link        = 1'b1;
                imm32_s              = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                                        in_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                ex_dec_s.alu_src_imm = 1'b1;
                ex_dec_s.jump        = 1'b1;
                ex_dec_s.jalr        = 1'b1;
                wb_dec_s.reg_write   = 1'b1;
                wb_dec_s.link        = 1'b1;
                imm32_s              = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            default: begin
                // SYSTEM/FENCE/illegal: no side effects, rs1 still counted as read.
                rs1_used_s = 1'b1;
            end
        endcase
    end

    // ---------------- ID/EX register ----------------
    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    out_pc_q, out_pc_d;
    logic [XLEN-1:0]    rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]    rs2_data_q, rs2_data_d;
    logic [AW-1:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]    immediate_q, immediate_d;
    ex_control_t        ex_ctrl_q, ex_ctrl_d;
    mem_control_t       mem_ctrl_q, mem_ctrl_d;
    wb_control_t        wb_ctrl_q, wb_ctrl_d;
    logic               stall_s;
    logic               in_ready_s;

    // Load-use hazard: the load in ID/EX writes a register the entering instruction reads.
    always_comb begin
        stall_s = out_valid_q && mem_ctrl_q.mem_read && (rd_addr_q != {AW{1'b0}}) && in_valid &&
                  ((rs1_used_s && (rs1_addr_s == rd_addr_q)) ||
                   (rs2_used_s && (rs2_addr_s == rd_addr_q)));
        in_ready_s = !stall_s && (!out_valid_q || out_ready);
    end

    // Next ID/EX state: flush, then capture, then drain (bubble), then hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        rd_addr_d   = rd_addr_q;
        immediate_d = immediate_q;
        ex_ctrl_d   = ex_ctrl_q;
        mem_ctrl_d  = mem_ctrl_q;
        wb_ctrl_d   = wb_ctrl_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_valid && in_ready_s) begin
            out_valid_d = 1'b1;
            out_pc_d    = in_pc;
            rs1_data_d  = rf_read(rs1_addr_s);
            rs2_data_d  = rf_read(rs2_addr_s);
            rd_addr_d   = rd_addr_s;
            immediate_d = XLEN'(imm32_s);
            ex_ctrl_d   = ex_dec_s;
            mem_ctrl_d  = mem_dec_s;
            wb_ctrl_d   = wb_dec_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= {XLEN{1'b0}};
            rs1_data_q  <= {XLEN{1'b0}};
            rs2_data_q  <= {XLEN{1'b0}};
            rd_addr_q   <= {AW{1'b0}};
            immediate_q <= {XLEN{1'b0}};
            ex_ctrl_q   <= '0;
            mem_ctrl_q  <= '0;
            wb_ctrl_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            rd_addr_q   <= rd_addr_d;
            immediate_q <= immediate_d;
            ex_ctrl_q   <= ex_ctrl_d;
            mem_ctrl_q  <= mem_ctrl_d;
            wb_ctrl_q   <= wb_ctrl_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign rs1_data  = rs1_data_q;
    assign rs2_data  = rs2_data_q;
    assign rd_addr   = rd_addr_q;
    assign immediate = immediate_q;
    assign ex_ctrl   = ex_ctrl_q;
    assign mem_ctrl  = mem_ctrl_q;
    assign wb_ctrl   = wb_ctrl_q;
    assign stall     = stall_s;
    assign in_ready  = in_ready_s;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Testbench for id_stage_pipe: directed scenarios followed by a randomized
// run checked against a transaction-level model of the stage.
module tb_id_stage_pipe;
    import id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic [31:0] immediate;
    ex_control_t  ex_ctrl;
    mem_control_t mem_ctrl;
    wb_control_t  wb_ctrl;
    logic        stall;

    int n_cmp = 0;
    int n_err = 0;

    id_stage_pipe #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
        .immediate(immediate), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
        .wb_ctrl(wb_ctrl), .stall(stall)
    );

    always #5 clk = ~clk;

    // Instruction encoders (immediate given as its numeric value).
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
            input logic [2:0] f3, input logic [4:0] rs1, input logic [31:0] imm);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
            input logic [2:0] f3, input logic [31:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [4:0] rs2, input logic [4:0] rs1,
            input logic [2:0] f3, input logic [31:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
            input logic [31:0] imm);
        return {imm[31:12], rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0000_0013; in_pc = 32'h0;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        // Load something, then reset asynchronously mid-cycle.
        in_valid = 1'b1; in_instr = enc_i(7'h13, 5'd3, 3'd0, 5'd0, 32'd7); in_pc = 32'h40;
        tick();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_reset out_valid got %b exp 0", out_valid); end
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset stall got %b exp 0", stall); end
        n_cmp++;
        if ({out_pc, rs1_data, rs2_data, immediate} !== 128'h0 || rd_addr !== 5'd0) begin
            n_err++; $display("FAIL reset payload got pc=%h rs1=%h rs2=%h imm=%h rd=%0d exp 0",
                              out_pc, rs1_data, rs2_data, immediate, rd_addr);
        end
        n_cmp++;
        if (ex_ctrl !== '0 || mem_ctrl !== '0 || wb_ctrl !== '0) begin
            n_err++; $display("FAIL reset ctrl got ex=%h mem=%h wb=%h exp 0", ex_ctrl, mem_ctrl, wb_ctrl);
        end
    endtask

    task automatic test_addi();
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        tick();
        wb_we = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h100;
        in_instr = enc_i(7'h13, 5'd6, 3'd0, 5'd5, 32'd1);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL addi in_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addi out_valid got %b exp 1", out_valid); end
        n_cmp++; if (rs1_data !== 32'h1234) begin n_err++; $display("FAIL addi rs1_data got %h exp 1234", rs1_data); end
        n_cmp++; if (immediate !== 32'd1) begin n_err++; $display("FAIL addi immediate got %h exp 1", immediate); end
        n_cmp++; if (rd_addr !== 5'd6) begin n_err++; $display("FAIL addi rd_addr got %0d exp 6", rd_addr); end
        n_cmp++; if (out_pc !== 32'h100) begin n_err++; $display("FAIL addi out_pc got %h exp 100", out_pc); end
        n_cmp++; if (wb_ctrl.reg_write !== 1'b1) begin n_err++; $display("FAIL addi reg_write got %b exp 1", wb_ctrl.reg_write); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL addi drain out_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_load_use();
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h100;
        tick();
        wb_addr = 5'd2; wb_data = 32'h22;
        tick();
        wb_we = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h300;
        in_instr = enc_i(7'h03, 5'd7, 3'b010, 5'd1, 32'd0);
        tick();
        n_cmp++; if (mem_ctrl.mem_read !== 1'b1 || rs1_data !== 32'h100) begin
            n_err++; $display("FAIL lu_load mem_read=%b rs1=%h exp 1/100", mem_ctrl.mem_read, rs1_data); end
        in_pc = 32'h304;
        in_instr = enc_r(7'h00, 5'd2, 5'd7, 3'd0, 5'd8);
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %b exp 1", stall); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lu_in_ready got %b exp 0", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble out_valid got %b exp 0", out_valid); end
        n_cmp++; if (stall !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL lu_release stall=%b in_ready=%b exp 0/1", stall, in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || rd_addr !== 5'd8 || rs2_data !== 32'h22 || out_pc !== 32'h304) begin
            n_err++; $display("FAIL lu_add v=%b rd=%0d rs2=%h pc=%h exp 1/8/22/304", out_valid, rd_addr, rs2_data, out_pc); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h200;
        in_instr = enc_i(7'h13, 5'd11, 3'd0, 5'd0, 32'h55);
        tick();
        in_pc = 32'h204;
        in_instr = enc_i(7'h13, 5'd12, 3'd0, 5'd0, 32'h66);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b1 || rd_addr !== 5'd11 || immediate !== 32'h55 || out_pc !== 32'h200) begin
                n_err++; $display("FAIL bp_hold v=%b rd=%0d imm=%h pc=%h exp 1/11/55/200", out_valid, rd_addr, immediate, out_pc); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release in_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || rd_addr !== 5'd12 || immediate !== 32'h66 || out_pc !== 32'h204) begin
            n_err++; $display("FAIL bp_next v=%b rd=%0d imm=%h pc=%h exp 1/12/66/204", out_valid, rd_addr, immediate, out_pc); end
        tick();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
        in_instr = enc_i(7'h13, 5'd13, 3'd0, 5'd0, 32'h9); in_pc = 32'h500;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush in_ready got %b exp 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_in out_valid got %b exp 0", out_valid); end
        flush = 1'b0; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_held out_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_wb_same_cycle();
        logic [31:0] exp_v;
        do_reset();
`ifdef ID_WB_BYPASS_EN
        exp_v = 32'hABCD;
`else
        exp_v = 32'h0;
`endif
        in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h600;
        in_instr = enc_r(7'h00, 5'd0, 5'd9, 3'd0, 5'd10);
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hABCD;
        tick();
        wb_we = 1'b0;
        n_cmp++; if (rs1_data !== exp_v) begin n_err++; $display("FAIL wb_same rs1_data got %h exp %h", rs1_data, exp_v); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (rs1_data !== 32'hABCD) begin n_err++; $display("FAIL wb_after rs1_data got %h exp abcd", rs1_data); end
        tick();
    endtask

    // ---------------- randomized run vs. transaction model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        bit          use1, use2, is_load, writes;
        logic [31:0] v1, v2;
    } txn_t;

    function automatic txn_t gen(input logic [4:0] hint, input logic [31:0] pc);
        txn_t t;
        int   kind, v;
        logic [19:0] u20;
        t.pc = pc; t.v1 = 32'h0; t.v2 = 32'h0;
        t.rd  = 5'($urandom_range(0, 31));
        t.rs1 = ($urandom_range(0, 1) == 1) ? hint : 5'($urandom_range(0, 31));
        t.rs2 = ($urandom_range(0, 2) == 0) ? hint : 5'($urandom_range(0, 31));
        t.use1 = 1'b1; t.use2 = 1'b0; t.is_load = 1'b0; t.writes = 1'b1;
        v = int'($urandom_range(0, 4095)) - 2048;
        t.imm = v;
        kind = $urandom_range(0, 8);
        case (kind)
            0: begin
                t.imm = 32'h0; t.use2 = 1'b1;
                t.instr = enc_r(($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, t.rs2, t.rs1, 3'($urandom_range(0, 7)), t.rd);
            end
            1: t.instr = enc_i(7'h13, t.rd, 3'b100, t.rs1, t.imm);
            2: begin t.is_load = 1'b1; t.instr = enc_i(7'h03, t.rd, 3'b010, t.rs1, t.imm); end
            3: begin t.use2 = 1'b1; t.writes = 1'b0; t.instr = enc_s(t.rs2, t.rs1, 3'b010, t.imm); end
            4: begin
                t.imm = v * 2; t.use2 = 1'b1; t.writes = 1'b0;
                t.instr = enc_b(t.rs2, t.rs1, 3'b001, t.imm);
            end
            5, 6: begin
                u20 = 20'($urandom); t.imm = {u20, 12'h000}; t.use1 = 1'b0;
                t.instr = enc_u((kind == 5) ? 7'b0110111 : 7'b0010111, t.rd, t.imm);
            end
            7: begin
                t.imm = (int'($urandom_range(0, 20'hFFFFF)) - 32'sh80000) * 2; t.use1 = 1'b0;
                t.instr = enc_j(t.rd, t.imm);
            end
            default: t.instr = enc_i(7'b1100111, t.rd, 3'b000, t.rs1, t.imm);
        endcase
        return t;
    endfunction

    task automatic test_random();
        txn_t        cur, slot;
        bit          ev, hz, rdy;
        logic [31:0] regs [32];
        logic [31:0] pc;
        do_reset();
        ev = 1'b0;
        for (int r = 0; r < 32; r++) regs[r] = 32'h0;
        slot = gen(5'd0, 32'h0);
        pc = 32'h1000;
        cur = gen(5'd0, pc);
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            wb_we     = ($urandom_range(0, 1) == 1);
            wb_addr   = ($urandom_range(0, 3) == 0) ? cur.rs1 : 5'($urandom_range(0, 31));
            wb_data   = $urandom;
            in_instr  = cur.instr;
            in_pc     = cur.pc;
            #1;
            hz  = ev && slot.is_load && (slot.rd != 5'd0) && in_valid &&
                  ((cur.use1 && cur.rs1 == slot.rd) || (cur.use2 && cur.rs2 == slot.rd));
            rdy = !hz && (!ev || out_ready);
            n_cmp++; if (stall !== hz) begin n_err++; $display("FAIL rnd_stall cyc %0d got %b exp %b", c, stall, hz); end
            n_cmp++; if (in_ready !== rdy) begin n_err++; $display("FAIL rnd_in_ready cyc %0d got %b exp %b", c, in_ready, rdy); end
            if (flush) begin
                ev = 1'b0;
            end else if (in_valid && rdy) begin
                slot = cur;
                slot.v1 = (cur.rs1 == 5'd0) ? 32'h0 : regs[cur.rs1];
                slot.v2 = (cur.rs2 == 5'd0) ? 32'h0 : regs[cur.rs2];
`ifdef ID_WB_BYPASS_EN
                if (wb_we && cur.rs1 != 5'd0 && wb_addr == cur.rs1) slot.v1 = wb_data;
                if (wb_we && cur.rs2 != 5'd0 && wb_addr == cur.rs2) slot.v2 = wb_data;
`endif
                ev = 1'b1;
            end else if (out_ready) begin
                ev = 1'b0;
            end
            if (in_valid && (flush || rdy)) begin
                pc = pc + 32'd4;
                cur = gen(cur.rd, pc);
            end
            if (wb_we && wb_addr != 5'd0) regs[wb_addr] = wb_data;
            tick();
            n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL rnd_out_valid cyc %0d got %b exp %b", c, out_valid, ev); end
            if (ev) begin
                n_cmp++;
                if (out_pc !== slot.pc || immediate !== slot.imm || mem_ctrl.mem_read !== slot.is_load ||
                    wb_ctrl.reg_write !== slot.writes) begin
                    n_err++; $display("FAIL rnd_payload cyc %0d instr %h pc=%h/%h imm=%h/%h ld=%b/%b wr=%b/%b",
                        c, slot.instr, out_pc, slot.pc, immediate, slot.imm, mem_ctrl.mem_read, slot.is_load,
                        wb_ctrl.reg_write, slot.writes);
                end
                n_cmp++;
                if ((slot.writes && rd_addr !== slot.rd) || (slot.use1 && rs1_data !== slot.v1) ||
                    (slot.use2 && rs2_data !== slot.v2)) begin
                    n_err++; $display("FAIL rnd_operands cyc %0d instr %h rd=%0d/%0d rs1=%h/%h rs2=%h/%h",
                        c, slot.instr, rd_addr, slot.rd, rs1_data, slot.v1, rs2_data, slot.v2);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_addi();
        test_load_use();
        test_backpressure();
        test_flush();
        test_wb_same_cycle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
